// File: rtl/cpu_mc_core_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_mc_core_if : instruction/data memory handshake bundle for cpu_mc_core
// Revision 1.0
// ----------------------------------------------------------------------------
interface cpu_mc_core_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        imem_valid_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [31:0] dmem_rdata_i;
  logic        dmem_valid_i;

  modport master (
    output imem_req_o, imem_addr_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    input  imem_rdata_i, imem_valid_i, dmem_rdata_i, dmem_valid_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    output imem_rdata_i, imem_valid_i, dmem_rdata_i, dmem_valid_i
  );
endinterface
`default_nettype wire

// File: rtl/cpu_mc_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_mc_core : multi-cycle RV32I-subset core with handshaked memories,
//               sticky trap, retire port and instret counter
// Revision 1.0
// ----------------------------------------------------------------------------
module cpu_mc_core #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          CNT_W        = 32,
  parameter bit          STRICT_ALIGN = 1'b1
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  cpu_mc_core_if.master         bus,
  output logic [31:0]           pc_o,
  output logic                  retire_o,
  output logic                  reg_write_en_o,
  output logic [4:0]            reg_write_addr_o,
  output logic [31:0]           reg_write_data_o,
  output logic                  trap_o,
  output logic [1:0]            trap_cause_o,
  output logic [CNT_W-1:0]      instret_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_imm, r_next_pc;
  logic [31:0] r_rf [32];
  logic        r_imem_req, r_dmem_req, r_dmem_we;
  logic [31:0] r_dmem_addr, r_dmem_wdata;
  logic        r_retire, r_rwe, r_trap;
  logic [4:0]  r_rwaddr;
  logic [31:0] r_rwdata;
  logic [1:0]  r_cause;
  logic [CNT_W-1:0] r_instret;

  logic [6:0]  w_opc, w_f7;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic        w_is_op, w_is_opi, w_is_lw, w_is_sw, w_is_br, w_is_jal, w_is_lui, w_is_sys;
  logic        w_legal, w_taken, w_wen;
  logic [31:0] w_imm, w_rs1v, w_rs2v, w_alu_b, w_alu, w_result, w_sum, w_target, w_pc4;

  assign w_opc = r_ir[6:0];
  assign w_rd  = r_ir[11:7];
  assign w_f3  = r_ir[14:12];
  assign w_rs1 = r_ir[19:15];
  assign w_rs2 = r_ir[24:20];
  assign w_f7  = r_ir[31:25];

  assign w_is_op  = (w_opc == 7'b0110011);
  assign w_is_opi = (w_opc == 7'b0010011);
  assign w_is_lw  = (w_opc == 7'b0000011);
  assign w_is_sw  = (w_opc == 7'b0100011);
  assign w_is_br  = (w_opc == 7'b1100011);
  assign w_is_jal = (w_opc == 7'b1101111);
  assign w_is_lui = (w_opc == 7'b0110111);
  assign w_is_sys = (r_ir == 32'h0000_0073) || (r_ir == 32'h0010_0073);

  always_comb begin
    w_legal = 1'b0;
    w_imm   = 32'h0;
    case (w_opc)
      7'b0110011: w_legal = ((w_f7 == 7'b0000000) && (w_f3 != 3'b011)) ||
                            ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
      7'b0010011: begin
        w_legal = w_f3 inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111};
        w_imm   = {{20{r_ir[31]}}, r_ir[31:20]};
      end
      7'b0000011: begin
        w_legal = (w_f3 == 3'b010);
        w_imm   = {{20{r_ir[31]}}, r_ir[31:20]};
      end
      7'b0100011: begin
        w_legal = (w_f3 == 3'b010);
        w_imm   = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
      end
      7'b1100011: begin
        w_legal = (w_f3 == 3'b000) || (w_f3 == 3'b001);
        w_imm   = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
      end
      7'b1101111: begin
        w_legal = 1'b1;
        w_imm   = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
      end
      7'b0110111: begin
        w_legal = 1'b1;
        w_imm   = {r_ir[31:12], 12'h000};
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_rs1v = (w_rs1 == 5'd0) ? 32'h0 : r_rf[w_rs1];
  assign w_rs2v = (w_rs2 == 5'd0) ? 32'h0 : r_rf[w_rs2];

  // ALU operands come from the DECODE-stage registers; r_ir is still valid in EXEC.
  assign w_alu_b = w_is_op ? r_b : r_imm;
  always_comb begin
    w_alu = 32'h0;
    case (w_f3)
      3'b000:  w_alu = (w_is_op && w_f7[5]) ? (r_a - w_alu_b) : (r_a + w_alu_b);
      3'b001:  w_alu = r_a << w_alu_b[4:0];
      3'b010:  w_alu = {31'h0, $signed(r_a) < $signed(w_alu_b)};
      3'b100:  w_alu = r_a ^ w_alu_b;
      3'b101:  w_alu = w_f7[5] ? 32'($signed(r_a) >>> w_alu_b[4:0]) : (r_a >> w_alu_b[4:0]);
      3'b110:  w_alu = r_a | w_alu_b;
      3'b111:  w_alu = r_a & w_alu_b;
      default: w_alu = 32'h0;
    endcase
  end

  assign w_sum    = r_a + r_imm;
  assign w_target = r_pc + r_imm;
  assign w_pc4    = r_pc + 32'd4;
  assign w_taken  = w_is_jal || (w_is_br && (w_f3[0] ? (r_a != r_b) : (r_a == r_b)));
  assign w_result = w_is_lui ? r_imm : (w_is_jal ? w_pc4 : w_alu);
  assign w_wen    = (w_is_op || w_is_opi || w_is_jal || w_is_lui) && (w_rd != 5'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_ir         <= 32'h0;
      r_a          <= 32'h0;
      r_b          <= 32'h0;
      r_imm        <= 32'h0;
      r_next_pc    <= 32'h0;
      for (int i = 0; i < 32; i++) r_rf[i] <= 32'h0;
      r_imem_req   <= 1'b0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= 32'h0;
      r_dmem_wdata <= 32'h0;
      r_retire     <= 1'b0;
      r_rwe        <= 1'b0;
      r_rwaddr     <= 5'd0;
      r_rwdata     <= 32'h0;
      r_trap       <= 1'b0;
      r_cause      <= 2'd0;
      r_instret    <= '0;
    end else begin
      r_retire <= 1'b0;
      if (r_retire) r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
      case (r_state)
        S_FETCH: begin
          // Request is raised on entry; only the first FETCH after reset starts idle.
          if (!r_imem_req) begin
            r_imem_req <= 1'b1;
          end else if (bus.imem_valid_i) begin
            r_ir       <= bus.imem_rdata_i;
            r_imem_req <= 1'b0;
            r_state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a   <= w_rs1v;
          r_b   <= w_rs2v;
          r_imm <= w_imm;
          if (w_is_sys) begin
            r_trap <= 1'b1; r_cause <= 2'd3; r_state <= S_TRAP;
          end else if (!w_legal) begin
            r_trap <= 1'b1; r_cause <= 2'd0; r_state <= S_TRAP;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_taken && (w_target[1:0] != 2'b00)) begin
            r_trap <= 1'b1; r_cause <= 2'd1; r_state <= S_TRAP;
          end else if (w_is_lw || w_is_sw) begin
            if (STRICT_ALIGN && (w_sum[1:0] != 2'b00)) begin
              r_trap <= 1'b1; r_cause <= 2'd2; r_state <= S_TRAP;
            end else begin
              r_dmem_req   <= 1'b1;
              r_dmem_we    <= w_is_sw;
              r_dmem_addr  <= STRICT_ALIGN ? w_sum : {w_sum[31:2], 2'b00};
              r_dmem_wdata <= r_b;
              r_state      <= S_MEM;
            end
          end else begin
            r_retire  <= 1'b1;
            r_rwe     <= w_wen;
            r_rwaddr  <= w_rd;
            r_rwdata  <= w_result;
            r_next_pc <= w_taken ? w_target : w_pc4;
            r_state   <= S_WB;
          end
        end
        S_MEM: begin
          if (bus.dmem_valid_i) begin
            r_dmem_req <= 1'b0;
            r_retire   <= 1'b1;
            if (r_dmem_we) begin
              r_pc       <= w_pc4;
              r_imem_req <= 1'b1;
              r_state    <= S_FETCH;
            end else begin
              r_rwe     <= (w_rd != 5'd0);
              r_rwaddr  <= w_rd;
              r_rwdata  <= bus.dmem_rdata_i;
              r_next_pc <= w_pc4;
              r_state   <= S_WB;
            end
          end
        end
        S_WB: begin
          if (r_rwe) r_rf[r_rwaddr] <= r_rwdata;
          r_rwe      <= 1'b0;
          r_pc       <= r_next_pc;
          r_imem_req <= 1'b1;
          r_state    <= S_FETCH;
        end
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_TRAP;
      endcase
    end
  end

  assign bus.imem_req_o   = r_imem_req;
  assign bus.imem_addr_o  = r_pc;
  assign bus.dmem_req_o   = r_dmem_req;
  assign bus.dmem_we_o    = r_dmem_we;
  assign bus.dmem_addr_o  = r_dmem_addr;
  assign bus.dmem_wdata_o = r_dmem_wdata;
  assign pc_o             = r_pc;
  assign retire_o         = r_retire;
  assign reg_write_en_o   = r_rwe;
  assign reg_write_addr_o = r_rwaddr;
  assign reg_write_data_o = r_rwdata;
  assign trap_o           = r_trap;
  assign trap_cause_o     = r_cause;
  assign instret_o        = r_instret;

endmodule
`default_nettype wire
